// File: rtl/pipelined_cla_adder_if.sv
// Valid/ready operand and result bundle for pipelined_cla_adder.
// out_ovf exists only when PIPE_CLA_OVF_EN is defined.
interface pipelined_cla_adder_if #(
  parameter int NBITS = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [NBITS-1:0] in_a;
  logic [NBITS-1:0] in_b;
  logic             in_cin;
  logic             in_sub;
  logic             out_valid;
  logic             out_ready;
  logic [NBITS-1:0] out_sum;
  logic             out_cout;
`ifdef PIPE_CLA_OVF_EN
  logic             out_ovf;

  modport master (
    output in_valid, in_a, in_b, in_cin, in_sub, out_ready,
    input  in_ready, out_valid, out_sum, out_cout, out_ovf
  );
  modport slave (
    input  in_valid, in_a, in_b, in_cin, in_sub, out_ready,
    output in_ready, out_valid, out_sum, out_cout, out_ovf
  );
`else
  modport master (
    output in_valid, in_a, in_b, in_cin, in_sub, out_ready,
    input  in_ready, out_valid, out_sum, out_cout
  );
  modport slave (
    input  in_valid, in_a, in_b, in_cin, in_sub, out_ready,
    output in_ready, out_valid, out_sum, out_cout
  );
`endif
endinterface

// File: rtl/pipelined_cla_adder.sv
// Elastic pipelined carry-lookahead adder/subtractor, one CW-bit chunk resolved per stage.
// Define PIPE_CLA_OVF_EN to add the signed-overflow output carried with each beat.
module pipelined_cla_adder #(
  parameter int NBITS   = 16,
  parameter int NSTAGES = 4
) (
  input logic                  clk,
  input logic                  rst_n,
  pipelined_cla_adder_if.slave bus
);
  localparam int CW = NBITS / NSTAGES;

  if (NBITS % NSTAGES != 0) begin : g_bad_cfg
    $error("NBITS must be divisible by NSTAGES");
  end

  function automatic logic [CW:0] cla_chunk(input logic [CW-1:0] a,
                                            input logic [CW-1:0] b,
                                            input logic          cin);
    logic [CW-1:0] g;
    logic [CW-1:0] p;
    logic [CW:0]   c;
    g    = a & b;
    p    = a ^ b;
    c[0] = cin;
    for (int i = 0; i < CW; i++) c[i+1] = g[i] | (p[i] & c[i]);
    return {c[CW], p ^ c[CW-1:0]};
  endfunction

  // a_q rotates right by CW per stage: the processed A chunk drops out at the
  // bottom and its sum chunk enters at the top, so the last stage holds the sum.
  logic [NBITS-1:0]   a_q  [NSTAGES];
  logic [NBITS-1:0]   b_q  [NSTAGES];
  logic [NSTAGES-1:0] c_q;
  logic [NSTAGES-1:0] v_q;
  logic [NSTAGES-1:0] adv;

  logic [NBITS-1:0]   a_in [NSTAGES];
  logic [NBITS-1:0]   b_in [NSTAGES];
  logic [NSTAGES-1:0] c_in;
  logic [NSTAGES-1:0] v_in;
  logic [NBITS-1:0]   a_nx [NSTAGES];
  logic [NBITS-1:0]   b_nx [NSTAGES];
  logic [CW-1:0]      s_nx [NSTAGES];
  logic [NSTAGES-1:0] c_nx;

  always_comb begin
    a_in[0] = bus.in_a;
    b_in[0] = bus.in_sub ? ~bus.in_b : bus.in_b;
    c_in[0] = bus.in_sub | bus.in_cin;
    v_in[0] = bus.in_valid;
    for (int k = 1; k < NSTAGES; k++) begin
      a_in[k] = a_q[k-1];
      b_in[k] = b_q[k-1];
      c_in[k] = c_q[k-1];
      v_in[k] = v_q[k-1];
    end
  end

  always_comb begin
    for (int k = 0; k < NSTAGES; k++) begin
      {c_nx[k], s_nx[k]} = cla_chunk(a_in[k][CW-1:0], b_in[k][CW-1:0], c_in[k]);
      a_nx[k] = (a_in[k] >> CW) | (NBITS'(s_nx[k]) << (NBITS - CW));
      b_nx[k] = b_in[k] >> CW;
    end
  end

  // A stage may load when the output drains or any stage at or beyond it is a bubble.
  always_comb begin
    for (int k = 0; k < NSTAGES; k++) begin
      adv[k] = bus.out_ready | (|(~v_q >> k));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q <= '0;
      c_q <= '0;
      for (int k = 0; k < NSTAGES; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < NSTAGES; k++) begin
        if (adv[k]) begin
          v_q[k] <= v_in[k];
          if (v_in[k]) begin
            a_q[k] <= a_nx[k];
            b_q[k] <= b_nx[k];
            c_q[k] <= c_nx[k];
          end
        end
      end
    end
  end

  assign bus.in_ready  = adv[0];
  assign bus.out_valid = v_q[NSTAGES-1];
  assign bus.out_sum   = a_q[NSTAGES-1];
  assign bus.out_cout  = c_q[NSTAGES-1];

`ifdef PIPE_CLA_OVF_EN
  logic ovf_nx;
  logic ovf_q;

  // The last stage sees the operand MSBs in the top bit of its chunk.
  always_comb begin
    ovf_nx = (a_in[NSTAGES-1][CW-1] == b_in[NSTAGES-1][CW-1]) &&
             (s_nx[NSTAGES-1][CW-1] != a_in[NSTAGES-1][CW-1]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else if (adv[NSTAGES-1] && v_in[NSTAGES-1]) begin
      ovf_q <= ovf_nx;
    end
  end

  assign bus.out_ovf = ovf_q;
`endif
endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Self-checking bench for pipelined_cla_adder: queue-based arithmetic model plus directed literals.
module tb_pipelined_cla_adder;
  localparam int NBITS   = 16;
  localparam int NSTAGES = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pipelined_cla_adder_if #(.NBITS(NBITS)) bus ();
  pipelined_cla_adder_if #(.NBITS(NBITS)) bus1 ();
  pipelined_cla_adder_if #(.NBITS(NBITS)) bus16 ();

  pipelined_cla_adder #(.NBITS(NBITS), .NSTAGES(NSTAGES)) dut   (.clk(clk), .rst_n(rst_n), .bus(bus));
  pipelined_cla_adder #(.NBITS(NBITS), .NSTAGES(1))       dut1  (.clk(clk), .rst_n(rst_n), .bus(bus1));
  pipelined_cla_adder #(.NBITS(NBITS), .NSTAGES(16))      dut16 (.clk(clk), .rst_n(rst_n), .bus(bus16));

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [NBITS-1:0] sum;
    logic             cout;
    logic             ovf;
  } exp_t;

  exp_t expq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Plain integer arithmetic: unsigned total for sum/cout, signed total for overflow.
  function automatic exp_t model(input logic [NBITS-1:0] a, input logic [NBITS-1:0] b,
                                 input logic cin, input logic sub);
    exp_t             e;
    logic [NBITS-1:0] bp;
    longint           cv;
    longint           u;
    longint           s;
    longint           lim;
    bp  = sub ? ~b : b;
    cv  = (sub || cin) ? 64'sd1 : 64'sd0;
    u   = longint'(a) + longint'(bp) + cv;
    s   = longint'($signed(a)) + longint'($signed(bp)) + cv;
    lim = 64'sd1 <<< (NBITS - 1);
    e.sum  = u[NBITS-1:0];
    e.cout = u[NBITS];
    e.ovf  = (s >= lim) || (s < -lim);
    return e;
  endfunction

  // Compare process: model expectations pushed on accept, checked on every emit and while held.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst_n) begin
      expq.delete();
    end else begin
      if (bus.in_valid && bus.in_ready)
        expq.push_back(model(bus.in_a, bus.in_b, bus.in_cin, bus.in_sub));
      if (bus.out_valid) begin
        if (expq.size() == 0) begin
          chk("unexpected_beat", 32'd1, 32'd0);
        end else begin
          e = expq[0];
          chk(bus.out_ready ? "model_sum" : "held_sum", 32'(bus.out_sum), 32'(e.sum));
          chk(bus.out_ready ? "model_cout" : "held_cout", 32'(bus.out_cout), 32'(e.cout));
`ifdef PIPE_CLA_OVF_EN
          chk(bus.out_ready ? "model_ovf" : "held_ovf", 32'(bus.out_ovf), 32'(e.ovf));
`endif
          if (bus.out_ready) void'(expq.pop_front());
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ops(input logic [NBITS-1:0] a, input logic [NBITS-1:0] b,
                         input logic cin, input logic sub);
    bus.in_a   = a;
    bus.in_b   = b;
    bus.in_cin = cin;
    bus.in_sub = sub;
  endtask

  // One beat into an empty pipe with out_ready=1; checks latency and the literal result.
  task automatic one_shot(input string name, input logic [NBITS-1:0] a, input logic [NBITS-1:0] b,
                          input logic cin, input logic sub, input logic [NBITS-1:0] x_sum,
                          input logic x_cout, input logic x_ovf);
    int lat;
    set_ops(a, b, cin, sub);
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    chk({name, "_ready"}, 32'(bus.in_ready), 32'd1);
    step();
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 50) begin
      step();
      lat++;
    end
    chk({name, "_latency"}, 32'(lat), 32'(NSTAGES));
    chk({name, "_sum"}, 32'(bus.out_sum), 32'(x_sum));
    chk({name, "_cout"}, 32'(bus.out_cout), 32'(x_cout));
`ifdef PIPE_CLA_OVF_EN
    chk({name, "_ovf"}, 32'(bus.out_ovf), 32'(x_ovf));
`else
    if (x_ovf === 1'bx) chk({name, "_ovf_lit"}, 32'(x_ovf), 32'd0);
`endif
    step();
  endtask

  task automatic drain(input string name);
    for (int n = 0; n < 200 && (expq.size() != 0 || bus.out_valid); n++) step();
    chk(name, 32'(expq.size()), 32'd0);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int acc;
    int lat;
    int lat1;
    int lat16;
    logic [NBITS-1:0] s1;
    logic [NBITS-1:0] s16;
    logic c1;
    logic c16;

    bus.in_valid = 1'b0;   bus.out_ready = 1'b1;
    bus1.in_valid = 1'b0;  bus1.out_ready = 1'b1;
    bus16.in_valid = 1'b0; bus16.out_ready = 1'b1;
    set_ops('0, '0, 1'b0, 1'b0);
    bus1.in_a = '0;  bus1.in_b = '0;  bus1.in_cin = 1'b0;  bus1.in_sub = 1'b0;
    bus16.in_a = '0; bus16.in_b = '0; bus16.in_cin = 1'b0; bus16.in_sub = 1'b0;

    #12;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_out_sum", 32'(bus.out_sum), 32'd0);
    chk("rst_out_cout", 32'(bus.out_cout), 32'd0);
`ifdef PIPE_CLA_OVF_EN
    chk("rst_out_ovf", 32'(bus.out_ovf), 32'd0);
`endif
    step();
    rst_n = 1'b1;
    step();
    chk("post_rst_in_ready", 32'(bus.in_ready), 32'd1);

    one_shot("wrap",    16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    one_shot("sub_neg", 16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    one_shot("sub_pos", 16'h1234, 16'h0234, 1'b0, 1'b1, 16'h1000, 1'b1, 1'b0);
    one_shot("cin_rip", 16'h0FFF, 16'h0000, 1'b1, 1'b0, 16'h1000, 1'b0, 1'b0);
    one_shot("sub_cin", 16'h0010, 16'h0001, 1'b1, 1'b1, 16'h000F, 1'b1, 1'b0);
    one_shot("ovf_add", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    one_shot("ovf_sub", 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
    one_shot("no_ovf",  16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0);

    // Back-to-back random beats; in_ready must never drop.
    bus.out_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      set_ops(NBITS'($urandom), NBITS'($urandom), 1'($urandom), 1'($urandom));
      bus.in_valid = 1'b1;
      chk("tput_in_ready", 32'(bus.in_ready), 32'd1);
      step();
    end
    bus.in_valid = 1'b0;
    drain("tput_drain");

    // Backpressure: fill, hold 10 cycles, then accept and emit together while full.
    bus.out_ready = 1'b0;
    acc = 0;
    set_ops(NBITS'($urandom), NBITS'($urandom), 1'($urandom), 1'b0);
    bus.in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (bus.in_ready) begin
        acc++;
        step();
        set_ops(NBITS'($urandom), NBITS'($urandom), 1'($urandom), 1'($urandom));
      end else begin
        step();
      end
    end
    chk("bp_accepted", 32'(acc), 32'(NSTAGES));
    chk("bp_in_ready_low", 32'(bus.in_ready), 32'd0);
    chk("bp_out_valid", 32'(bus.out_valid), 32'd1);
    bus.out_ready = 1'b1;
    #1;
    chk("full_accept_emit", 32'(bus.in_ready), 32'd1);
    for (int i = 0; i < 5; i++) begin
      step();
      set_ops(NBITS'($urandom), NBITS'($urandom), 1'($urandom), 1'($urandom));
      chk("full_stream_ready", 32'(bus.in_ready), 32'd1);
    end
    bus.in_valid = 1'b0;
    drain("bp_drain");

    // Reset with 3 beats in flight: everything discarded, nothing stale afterwards.
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_ops(16'h1111 * 16'(i + 1), 16'h0101, 1'b0, 1'b0);
      step();
    end
    bus.in_valid = 1'b0;
    step();
    step();
    chk("pre_rst_out_valid", 32'(bus.out_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("mid_rst_out_sum", 32'(bus.out_sum), 32'd0);
    chk("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
    step();
    step();
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 2 * NSTAGES; i++) begin
      step();
      chk("post_rst_no_stale", 32'(bus.out_valid), 32'd0);
    end

    // Latency of the single-stage and fully split variants.
    bus1.in_a = 16'hFFFF;  bus1.in_b = 16'h0001;  bus1.in_valid = 1'b1;
    bus16.in_a = 16'hFFFF; bus16.in_b = 16'h0001; bus16.in_valid = 1'b1;
    step();
    bus1.in_valid = 1'b0;
    bus16.in_valid = 1'b0;
    lat1 = -1; lat16 = -1;
    s1 = '1; s16 = '1; c1 = 1'b0; c16 = 1'b0;
    for (lat = 1; lat <= 40 && (lat1 < 0 || lat16 < 0); lat++) begin
      if (bus1.out_valid && lat1 < 0) begin
        lat1 = lat; s1 = bus1.out_sum; c1 = bus1.out_cout;
      end
      if (bus16.out_valid && lat16 < 0) begin
        lat16 = lat; s16 = bus16.out_sum; c16 = bus16.out_cout;
      end
      step();
    end
    chk("n1_latency", 32'(lat1), 32'd1);
    chk("n1_sum", 32'(s1), 32'h0000);
    chk("n1_cout", 32'(c1), 32'd1);
    chk("n16_latency", 32'(lat16), 32'd16);
    chk("n16_sum", 32'(s16), 32'h0000);
    chk("n16_cout", 32'(c16), 32'd1);

    step();
    chk("final_queue_empty", 32'(expq.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
